spi_snoop_rx: RTL

Clocked, oversampling SPI receiver that passively snoops the sensor's SPI bus (shared SCK/CS/MISO with the RP2350) and delivers each sensor sample as a parallel big-endian word with a one-cycle valid strobe. It sits directly upstream of the Kalman filter stage and replaces the SCK-clocked deserializer. All logic runs in the FPGA system clock domain, so downstream stages see a real clock rather than a data-derived strobe. Malformed frames are detected and flagged instead of forwarded.

---
 rtl/spi_snoop_pkg.sv | 23 ++
 rtl/sync_edge_det.sv | 40 ++++
 rtl/spi_snoop_rx.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/spi_snoop_pkg.sv
// Shared types and default widths for the SPI snoop receiver.
// Contents: snoop_state_t FSM encoding, default parameter values, max_u helper.
// Optional feature macro used by the top: SPI_SNOOP_STATS_EN.
package spi_snoop_pkg;

   localparam int unsigned DEFAULT_DATA_W      = 16;
   localparam int unsigned DEFAULT_SKIP_BITS   = 8;
   localparam int unsigned DEFAULT_SYNC_STAGES = 2;
   localparam int unsigned STATS_W             = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SKIP  = 2'd1,
      SHIFT = 2'd2,
      HOLD  = 2'd3
   } snoop_state_t;

   // Larger of two unsigned values, usable in constant expressions.
   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer with one-cycle registered rise/fall detection.
// Ports:
//   clk, rst : system clock, synchronous active-high reset
//   din      : asynchronous input
//   level    : synchronized level, time-aligned with rise/fall
//   rise     : one-cycle pulse when the synchronized level goes 0 -> 1
//   fall     : one-cycle pulse when the synchronized level goes 1 -> 0
module sync_edge_det #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] chain;
   logic              prev;

   // Synchronizer chain, previous-value flop and registered edge strobes.
   always_ff @(posedge clk) begin
      if (rst) begin
         chain <= '0;
         prev  <= 1'b0;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         chain <= {chain[STAGES-2:0], din};
         prev  <= chain[STAGES-1];
         rise  <= chain[STAGES-1] & ~prev;
         fall  <= ~chain[STAGES-1] & prev;
      end
   end

   // prev holds the very sample that produced the current rise/fall strobe.
   assign level = prev;

endmodule

// File: rtl/spi_snoop_rx.sv
// Passive, oversampling SPI (mode 0) snoop receiver. Skips SKIP_BITS leading
// SCK edges, captures DATA_W bits MSB first and presents them on data_out with
// a one-cycle data_ready. Truncated or overrun frames pulse frame_err instead.
// Ports:
//   clk, rst     : system clock (>= 4x SCK), synchronous active-high reset
//   rp2350_sck   : async bus clock
//   rp2350_cs    : async chip select, active low
//   rp2350_miso  : async sensor data
//   data_out     : last good sample, held between frames
//   data_ready   : one-cycle pulse when data_out updates
//   frame_err    : one-cycle pulse on truncated/overrun frame
//   busy         : high while the FSM is not IDLE
//   frame_cnt, err_cnt : saturating 16-bit counters, only with SPI_SNOOP_STATS_EN
module spi_snoop_rx
   import spi_snoop_pkg::*;
#(
   parameter int unsigned DATA_W      = DEFAULT_DATA_W,
   parameter int unsigned SKIP_BITS   = DEFAULT_SKIP_BITS,
   parameter int unsigned SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rp2350_sck,
   input  logic              rp2350_cs,
   input  logic              rp2350_miso,
   output logic [DATA_W-1:0] data_out,
   output logic              data_ready,
   output logic              frame_err,
   output logic              busy
`ifdef SPI_SNOOP_STATS_EN
   ,
   output logic [STATS_W-1:0] frame_cnt,
   output logic [STATS_W-1:0] err_cnt
`endif
);

   localparam int unsigned CNT_W = $clog2(max_u(SKIP_BITS, DATA_W) + 1);
   localparam logic [CNT_W-1:0] SKIP_LAST = CNT_W'((SKIP_BITS > 0) ? SKIP_BITS - 1 : 0);
   localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

   logic sck_rise, sck_level_unused, sck_fall_unused;
   logic cs_rise, cs_fall, cs_level_unused;
   logic miso_s, miso_rise_unused, miso_fall_unused;

   sync_edge_det #(.STAGES(SYNC_STAGES)) u_sck (
      .clk(clk), .rst(rst), .din(rp2350_sck),
      .level(sck_level_unused), .rise(sck_rise), .fall(sck_fall_unused)
   );

   sync_edge_det #(.STAGES(SYNC_STAGES)) u_cs (
      .clk(clk), .rst(rst), .din(rp2350_cs),
      .level(cs_level_unused), .rise(cs_rise), .fall(cs_fall)
   );

   sync_edge_det #(.STAGES(SYNC_STAGES)) u_miso (
      .clk(clk), .rst(rst), .din(rp2350_miso),
      .level(miso_s), .rise(miso_rise_unused), .fall(miso_fall_unused)
   );

   snoop_state_t      state, state_next;
   logic [CNT_W-1:0]  cnt, cnt_next;
   logic [DATA_W-1:0] sr, sr_next;
   logic [DATA_W-1:0] data_next;
   logic              ready_next, err_next, busy_next;
   logic              overrun, overrun_next;

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         cnt        <= '0;
         sr         <= '0;
         data_out   <= '0;
         data_ready <= 1'b0;
         frame_err  <= 1'b0;
         busy       <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         state      <= state_next;
         cnt        <= cnt_next;
         sr         <= sr_next;
         data_out   <= data_next;
         data_ready <= ready_next;
         frame_err  <= err_next;
         busy       <= busy_next;
         overrun    <= overrun_next;
      end
   end

   // Next-state logic; a CS rise always wins over an SCK rise in the same cycle.
   always_comb begin
      state_next   = state;
      cnt_next     = cnt;
      sr_next      = sr;
      data_next    = data_out;
      ready_next   = 1'b0;
      err_next     = 1'b0;
      overrun_next = overrun;

      case (state)
         IDLE: begin
            if (cs_fall) begin
               cnt_next   = '0;
               state_next = (SKIP_BITS > 0) ? SKIP : SHIFT;
            end
         end
         SKIP: begin
            if (cs_rise) begin
               err_next   = 1'b1;
               state_next = IDLE;
            end else if (sck_rise) begin
               if (cnt == SKIP_LAST) begin
                  cnt_next   = '0;
                  state_next = SHIFT;
               end else begin
                  cnt_next = cnt + CNT_W'(1);
               end
            end
         end
         SHIFT: begin
            if (cs_rise) begin
               err_next   = 1'b1;
               state_next = IDLE;
            end else if (sck_rise) begin
               sr_next = {sr[DATA_W-2:0], miso_s};
               if (cnt == DATA_LAST) begin
                  data_next  = sr_next;
                  ready_next = 1'b1;
                  state_next = HOLD;
               end else begin
                  cnt_next = cnt + CNT_W'(1);
               end
            end
         end
         HOLD: begin
            if (cs_rise) begin
               err_next     = overrun;
               overrun_next = 1'b0;
               state_next   = IDLE;
            end else if (sck_rise) begin
               overrun_next = 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase

      busy_next = (state_next != IDLE);
   end

`ifdef SPI_SNOOP_STATS_EN
   // Saturating frame and error counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         frame_cnt <= '0;
         err_cnt   <= '0;
      end else begin
         if (data_ready && (frame_cnt != '1)) frame_cnt <= frame_cnt + STATS_W'(1);
         if (frame_err && (err_cnt != '1))    err_cnt   <= err_cnt + STATS_W'(1);
      end
   end
`endif

endmodule
